// File: rtl/cmd_pkg.sv
// Shared definitions for the command path: command codes, response status
// bytes and the state encodings used by the executor and its response sequencer.
package cmd_pkg;

    // Command codes produced by command_decoder
    localparam logic [7:0] CMD_WRITE = 8'h10;
    localparam logic [7:0] CMD_READ  = 8'h20;
    localparam logic [7:0] CMD_PING  = 8'h30;

    // Response status bytes
    localparam logic [7:0] ST_ACK      = 8'h06;
    localparam logic [7:0] ST_PONG     = 8'h55;
    localparam logic [7:0] ST_NAK_CMD  = 8'h15;
    localparam logic [7:0] ST_NAK_ADDR = 8'h16;
    localparam logic [7:0] ST_TIMEOUT  = 8'hEF;
    localparam logic [7:0] ST_DEC_ERR  = 8'hE0;

    // Executor states; RESPOND covers the whole SEND_STATUS / GAP / SEND_WORD
    // handshake, which the response sequencer walks through on its own.
    typedef enum logic [2:0] {
        EX_IDLE,
        EX_DECODE,
        EX_WRITE,
        EX_READ_REQ,
        EX_READ_WAIT,
        EX_RESPOND
    } exec_state_t;

    // Response sequencer states
    typedef enum logic [1:0] {
        RS_IDLE,
        RS_SEND_STATUS,
        RS_GAP,
        RS_SEND_WORD
    } resp_state_t;

    // Status byte reported for a frame the decoder already flagged as bad
    function automatic logic [7:0] dec_err_status(input logic [1:0] err);
        return ST_DEC_ERR | {6'b0, err};
    endfunction

endpackage

// File: rtl/cmd_executor_resp_sequencer.sv
// Response sequencer: sends a status byte, then optionally a data word, through
// a byte/word transmitter. tx_enable is held until tx_done and always drops for
// at least one cycle (GAP) between transfers. o_done pulses when finished.
module resp_sequencer
    import cmd_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic [31:0] i_word,
    input  logic        i_word_pending,
    input  logic        i_tx_done,
    output logic        o_tx_enable,
    output logic        o_tx_mode_select,
    output logic [7:0]  o_tx_byte,
    output logic [31:0] o_tx_word,
    output logic        o_done
);

    resp_state_t r_state;
    resp_state_t w_state_next;
    logic [7:0]  r_byte;
    logic [31:0] r_word;
    logic        r_pending;

    // State register plus request latch; the request is frozen at start so the
    // transmitter sees stable byte/word/mode for the whole enable window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= RS_IDLE;
            r_byte    <= 8'h00;
            r_word    <= 32'h0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == RS_IDLE && i_start) begin
                r_byte    <= i_byte;
                r_word    <= i_word;
                r_pending <= i_word_pending;
            end else if (r_state == RS_GAP && r_pending) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Next state and handshake outputs; tx_done is only honoured while sending.
    always_comb begin
        w_state_next     = r_state;
        o_tx_enable      = 1'b0;
        o_tx_mode_select = 1'b0;
        o_done           = 1'b0;
        case (r_state)
            RS_IDLE: begin
                if (i_start) w_state_next = RS_SEND_STATUS;
            end
            RS_SEND_STATUS: begin
                o_tx_enable = 1'b1;
                if (i_tx_done) w_state_next = RS_GAP;
            end
            RS_GAP: begin
                if (r_pending) begin
                    w_state_next = RS_SEND_WORD;
                end else begin
                    w_state_next = RS_IDLE;
                    o_done       = 1'b1;
                end
            end
            RS_SEND_WORD: begin
                o_tx_enable      = 1'b1;
                o_tx_mode_select = 1'b1;
                if (i_tx_done) w_state_next = RS_GAP;
            end
            default: w_state_next = RS_IDLE;
        endcase
    end

    assign o_tx_byte = r_byte;
    assign o_tx_word = r_word;

endmodule

// File: rtl/cmd_executor.sv
// Command executor: captures one decoded frame at a time, validates it, runs a
// single word write or read against the memory port, and hands the response
// (status byte, optional read word) to the response sequencer.
module cmd_executor
    import cmd_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  i_command,
    input  logic [14:0] i_address,
    input  logic [31:0] i_data,
    input  logic        i_done,
    input  logic [1:0]  i_error,
    output logic [14:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    output logic        o_mem_re,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_tx_enable,
    output logic        o_tx_mode_select,
    output logic [7:0]  o_tx_byte,
    output logic [31:0] o_tx_word,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam int          CNT_W       = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [31:0] MEM_DEPTH_U = 32'(MEM_DEPTH);

    exec_state_t      r_state;
    exec_state_t      w_state_next;
    logic [7:0]       r_command;
    logic [14:0]      r_address;
    logic [31:0]      r_data;
    logic [1:0]       r_error;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overrun;

    logic             w_resp_start;
    logic [7:0]       w_resp_byte;
    logic [31:0]      w_resp_word;
    logic             w_resp_pending;
    logic             w_resp_done;
    logic             w_known_cmd;
    logic             w_addr_bad;

    assign w_known_cmd = (r_command == CMD_WRITE) || (r_command == CMD_READ) ||
                         (r_command == CMD_PING);
    assign w_addr_bad  = ({17'd0, r_address} >= MEM_DEPTH_U);

    // State, frame capture (IDLE only), read timeout counter and sticky overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= EX_IDLE;
            r_command <= 8'h00;
            r_address <= 15'h0;
            r_data    <= 32'h0;
            r_error   <= 2'b00;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == EX_IDLE && i_done) begin
                r_command <= i_command;
                r_address <= i_address;
                r_data    <= i_data;
                r_error   <= i_error;
            end
            if (r_state != EX_IDLE && i_done) begin
                r_overrun <= 1'b1;
            end
            if (r_state == EX_READ_REQ) begin
                r_cnt <= '0;
            end else if (r_state == EX_READ_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and response request; the decode checks run in priority order.
    always_comb begin
        w_state_next   = r_state;
        w_resp_start   = 1'b0;
        w_resp_byte    = ST_ACK;
        w_resp_word    = 32'h0;
        w_resp_pending = 1'b0;
        case (r_state)
            EX_IDLE: begin
                if (i_done) w_state_next = EX_DECODE;
            end
            EX_DECODE: begin
                if (r_error != 2'b00) begin
                    w_resp_start = 1'b1;
                    w_resp_byte  = dec_err_status(r_error);
                    w_state_next = EX_RESPOND;
                end else if (!w_known_cmd) begin
                    w_resp_start = 1'b1;
                    w_resp_byte  = ST_NAK_CMD;
                    w_state_next = EX_RESPOND;
                end else if (r_command != CMD_PING && w_addr_bad) begin
                    w_resp_start = 1'b1;
                    w_resp_byte  = ST_NAK_ADDR;
                    w_state_next = EX_RESPOND;
                end else if (r_command == CMD_PING) begin
                    w_resp_start = 1'b1;
                    w_resp_byte  = ST_PONG;
                    w_state_next = EX_RESPOND;
                end else if (r_command == CMD_WRITE) begin
                    w_state_next = EX_WRITE;
                end else begin
                    w_state_next = EX_READ_REQ;
                end
            end
            EX_WRITE: begin
                w_resp_start = 1'b1;
                w_resp_byte  = ST_ACK;
                w_state_next = EX_RESPOND;
            end
            EX_READ_REQ: begin
                w_state_next = EX_READ_WAIT;
            end
            EX_READ_WAIT: begin
                // Data arriving in the last allowed cycle still counts as a hit.
                if (i_mem_valid) begin
                    w_resp_start   = 1'b1;
                    w_resp_byte    = ST_ACK;
                    w_resp_word    = i_mem_rdata;
                    w_resp_pending = 1'b1;
                    w_state_next   = EX_RESPOND;
                end else if (r_cnt == CNT_LAST) begin
                    w_resp_start = 1'b1;
                    w_resp_byte  = ST_TIMEOUT;
                    w_state_next = EX_RESPOND;
                end
            end
            EX_RESPOND: begin
                if (w_resp_done) w_state_next = EX_IDLE;
            end
            default: w_state_next = EX_IDLE;
        endcase
    end

    assign o_mem_addr  = r_address;
    assign o_mem_wdata = r_data;
    assign o_mem_we    = (r_state == EX_WRITE);
    assign o_mem_re    = (r_state == EX_READ_REQ);
    assign o_busy      = (r_state != EX_IDLE);
    assign o_overrun   = r_overrun;

    resp_sequencer u_resp (
        .clock            (clock),
        .reset            (reset),
        .i_start          (w_resp_start),
        .i_byte           (w_resp_byte),
        .i_word           (w_resp_word),
        .i_word_pending   (w_resp_pending),
        .i_tx_done        (i_tx_done),
        .o_tx_enable      (o_tx_enable),
        .o_tx_mode_select (o_tx_mode_select),
        .o_tx_byte        (o_tx_byte),
        .o_tx_word        (o_tx_word),
        .o_done           (w_resp_done)
    );

endmodule

// File: tb/tb_cmd_executor.sv
// Directed bench for cmd_executor: a vector table of single frames plus
// hand-written overrun and reset-during-read sequences.
module tb_cmd_executor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_command = 8'h00;
    logic [14:0] i_address = 15'h0;
    logic [31:0] i_data = 32'h0;
    logic        i_done = 1'b0;
    logic [1:0]  i_error = 2'b00;
    logic [14:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_we;
    logic        o_mem_re;
    logic [31:0] i_mem_rdata = 32'h0;
    logic        i_mem_valid = 1'b0;
    logic        o_tx_enable;
    logic        o_tx_mode_select;
    logic [7:0]  o_tx_byte;
    logic [31:0] o_tx_word;
    logic        i_tx_done = 1'b0;
    logic        o_busy;
    logic        o_overrun;

    int checks = 0;
    int errors = 0;

    cmd_executor #(.MEM_DEPTH(1024), .RD_TIMEOUT(64)) dut (
        .clock            (clock),
        .reset            (reset),
        .i_command        (i_command),
        .i_address        (i_address),
        .i_data           (i_data),
        .i_done           (i_done),
        .i_error          (i_error),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .o_mem_we         (o_mem_we),
        .o_mem_re         (o_mem_re),
        .i_mem_rdata      (i_mem_rdata),
        .i_mem_valid      (i_mem_valid),
        .o_tx_enable      (o_tx_enable),
        .o_tx_mode_select (o_tx_mode_select),
        .o_tx_byte        (o_tx_byte),
        .o_tx_word        (o_tx_word),
        .i_tx_done        (i_tx_done),
        .o_busy           (o_busy),
        .o_overrun        (o_overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [14:0] addr;
        logic [31:0] data;
        logic [1:0]  err;
        int          mem_lat;   // cycles from o_mem_re to i_mem_valid; 0 = never
        logic [31:0] mem_word;
        int          exp_we;
        int          exp_re;
        logic [7:0]  exp_byte;
        int          exp_nsend; // 1 = status only, 2 = status + word
        int          exp_lat;   // cycles from i_done cycle to first tx_enable
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one frame and follow it cycle by cycle until o_busy falls.
    task automatic run_vec(input vec_t v);
        int we_cnt = 0, re_cnt = 0, re_t = -1, n_rise = 0, en_len = 0;
        int lat = -1, done_t = -1, end_t = -1;
        logic [14:0] strobe_addr = '0;
        logic [31:0] we_data = '0, word = '0, held_word = '0;
        logic [7:0]  byte1 = '0, held_byte = '0;
        logic        mode1 = 1'b1, mode2 = 1'b0, held_mode = 1'b0;
        logic        gap_bad = 1'b0, unstable = 1'b0;
        @(negedge clock);
        i_command = v.cmd; i_address = v.addr; i_data = v.data; i_error = v.err; i_done = 1'b1;
        for (int t = 1; t < 200; t++) begin
            @(negedge clock);
            i_done = 1'b0; i_tx_done = 1'b0; i_mem_valid = 1'b0;
            if (o_mem_we) begin we_cnt++; strobe_addr = o_mem_addr; we_data = o_mem_wdata; end
            if (o_mem_re) begin re_cnt++; re_t = t; strobe_addr = o_mem_addr; end
            if (done_t >= 0 && t == done_t + 1 && o_tx_enable) gap_bad = 1'b1;
            if (o_tx_enable) begin
                if (en_len == 0) begin
                    n_rise++;
                    if (n_rise == 1) begin lat = t; byte1 = o_tx_byte; mode1 = o_tx_mode_select; end
                    else begin mode2 = o_tx_mode_select; word = o_tx_word; end
                    held_byte = o_tx_byte; held_mode = o_tx_mode_select; held_word = o_tx_word;
                end else if (o_tx_byte !== held_byte || o_tx_mode_select !== held_mode ||
                             o_tx_word !== held_word) begin
                    unstable = 1'b1;
                end
                en_len++;
                if (en_len == 2) begin i_tx_done = 1'b1; done_t = t; end
            end else begin
                en_len = 0;
            end
            if (v.mem_lat > 0 && re_t >= 0 && t == re_t + v.mem_lat) begin
                i_mem_valid = 1'b1; i_mem_rdata = v.mem_word;
            end
            if (!o_busy) begin end_t = t; break; end
        end
        i_tx_done = 1'b0; i_mem_valid = 1'b0;
        chk({v.name, " finished"}, 32'(end_t >= 0), 32'd1);
        chk({v.name, " we_count"}, 32'(we_cnt), 32'(v.exp_we));
        chk({v.name, " re_count"}, 32'(re_cnt), 32'(v.exp_re));
        if (v.exp_we + v.exp_re > 0) chk({v.name, " mem_addr"}, 32'(strobe_addr), 32'(v.addr));
        if (v.exp_we > 0) chk({v.name, " mem_wdata"}, we_data, v.data);
        chk({v.name, " status_byte"}, 32'(byte1), 32'(v.exp_byte));
        chk({v.name, " status_mode"}, 32'(mode1), 32'd0);
        chk({v.name, " sends"}, 32'(n_rise), 32'(v.exp_nsend));
        chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        if (v.exp_nsend == 2) begin
            chk({v.name, " word_mode"}, 32'(mode2), 32'd1);
            chk({v.name, " word"}, word, v.mem_word);
        end
        chk({v.name, " gap"}, 32'(gap_bad), 32'd0);
        chk({v.name, " stable"}, 32'(unstable), 32'd0);
        chk({v.name, " busy_fall"}, 32'(end_t), 32'(done_t + 2));
        $display("txn %s: cmd=%h addr=%h err=%0d byte=%h sends=%0d lat=%0d we=%0d re=%0d",
                 v.name, v.cmd, v.addr, v.err, byte1, n_rise, lat, we_cnt, re_cnt);
    endtask

    initial begin
        int we_seen;
        vecs[0]  = '{"ping",        8'h30, 15'd0,     32'h0,        2'd0, 0,  32'h0,        0, 0, 8'h55, 1, 2};
        vecs[1]  = '{"write",       8'h10, 15'h0005,  32'h00FF12CD, 2'd0, 0,  32'h0,        1, 0, 8'h06, 1, 3};
        vecs[2]  = '{"read",        8'h20, 15'h0005,  32'h0,        2'd0, 3,  32'h00FF12CD, 0, 1, 8'h06, 2, 6};
        vecs[3]  = '{"bad_cmd",     8'hAB, 15'd0,     32'h0,        2'd0, 0,  32'h0,        0, 0, 8'h15, 1, 2};
        vecs[4]  = '{"wr_addr1024", 8'h10, 15'd1024,  32'h12345678, 2'd0, 0,  32'h0,        0, 0, 8'h16, 1, 2};
        vecs[5]  = '{"dec_err2",    8'h10, 15'd1,     32'h0,        2'd2, 0,  32'h0,        0, 0, 8'hE2, 1, 2};
        vecs[6]  = '{"rd_timeout",  8'h20, 15'd9,     32'h0,        2'd0, 0,  32'h0,        0, 1, 8'hEF, 1, 67};
        vecs[7]  = '{"rd_1023",     8'h20, 15'd1023,  32'h0,        2'd0, 1,  32'hDEADBEEF, 0, 1, 8'h06, 2, 4};
        vecs[8]  = '{"wr_1023",     8'h10, 15'd1023,  32'hA5A55A5A, 2'd0, 0,  32'h0,        1, 0, 8'h06, 1, 3};
        vecs[9]  = '{"rd_7fff",     8'h20, 15'h7FFF,  32'h0,        2'd0, 0,  32'h0,        0, 0, 8'h16, 1, 2};
        vecs[10] = '{"ping_err1",   8'h30, 15'd0,     32'h0,        2'd1, 0,  32'h0,        0, 0, 8'hE1, 1, 2};
        vecs[11] = '{"rd_last_cyc", 8'h20, 15'd100,   32'h0,        2'd0, 64, 32'hCAFEF00D, 0, 1, 8'h06, 2, 67};

        // Reset state
        repeat (3) @(negedge clock);
        chk("reset_outputs", {o_mem_we, o_mem_re, o_tx_enable, o_tx_mode_select, o_busy, o_overrun,
                              o_tx_byte, 18'h0}, 32'h0);
        chk("reset_data", o_tx_word | o_mem_wdata | 32'(o_mem_addr), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Overrun: a second frame during SEND_STATUS is flagged and dropped.
        chk("ovr_pre", 32'(o_overrun), 32'd0);
        @(negedge clock);
        i_command = 8'h30; i_address = 15'd0; i_error = 2'd0; i_done = 1'b1;
        @(negedge clock); i_done = 1'b0;
        @(negedge clock);
        chk("ovr_status_enable", 32'(o_tx_enable), 32'd1);
        i_command = 8'h10; i_address = 15'd9; i_data = 32'h11112222; i_done = 1'b1;
        @(negedge clock); i_done = 1'b0;
        chk("ovr_set", 32'(o_overrun), 32'd1);
        i_tx_done = 1'b1;
        we_seen = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clock); i_tx_done = 1'b0;
            if (o_mem_we) we_seen++;
        end
        chk("ovr_dropped_we", 32'(we_seen), 32'd0);
        chk("ovr_idle", 32'(o_busy), 32'd0);
        chk("ovr_sticky", 32'(o_overrun), 32'd1);
        $display("txn overrun: overrun=%0d we_seen=%0d", o_overrun, we_seen);

        // Reset while waiting for read data drops everything at once.
        @(negedge clock);
        i_command = 8'h20; i_address = 15'd3; i_done = 1'b1;
        @(negedge clock); i_done = 1'b0;
        repeat (9) @(negedge clock);
        chk("rst_wait_busy", 32'(o_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_outputs", {o_mem_we, o_mem_re, o_tx_enable, o_tx_mode_select, o_busy, o_overrun,
                                  o_tx_byte, 18'h0}, 32'h0);
        chk("rst_async_data", o_tx_word | o_mem_wdata | 32'(o_mem_addr), 32'h0);
        @(negedge clock); reset = 1'b0;
        $display("txn reset_in_read: busy=%0d overrun=%0d", o_busy, o_overrun);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
